// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and ROM request payload for the sprite line scheduler.
package sprite_pkg;

    localparam logic [1:0] ORIENT_UP    = 2'd0;
    localparam logic [1:0] ORIENT_RIGHT = 2'd1;
    localparam logic [1:0] ORIENT_DOWN  = 2'd2;
    localparam logic [1:0] ORIENT_LEFT  = 2'd3;

    localparam logic [3:0] SPRITE_ID_EMPTY = 4'hF;
    localparam logic [7:0] BLANK_ROW       = 8'hFF;

    localparam int unsigned SPRITE_HEIGHT = 8;
    localparam int unsigned ROW_IDX_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]           sprite_id;
        logic [1:0]           orientation;
        logic [ROW_IDX_W-1:0] line_index;
    } rom_req_t;

endpackage

// File: rtl/sprite_row_hit.sv
// Combinational row test for one entity slot: does its 8-row sprite cover scanline i_y.
module sprite_row_hit #(
    parameter int unsigned Y_WIDTH = 10
) (
    input  logic [Y_WIDTH-1:0] i_y,
    input  logic [Y_WIDTH-1:0] i_ent_y,
    input  logic               i_valid,
    output logic               o_hit_c,
    output logic [2:0]         o_line_index_c
);
    import sprite_pkg::*;

    logic [Y_WIDTH-1:0] w_diff;

    // Modulo subtraction lets sprites straddling the Y wrap still hit.
    assign w_diff         = i_y - i_ent_y;
    assign o_hit_c        = i_valid && (w_diff < Y_WIDTH'(SPRITE_HEIGHT));
    assign o_line_index_c = w_diff[2:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite ROM sequencer with shadow line buffer and atomic commit.
// Optional hit cap per line enabled by defining SPRITE_LINE_LIMIT_EN.
module sprite_line_scheduler #(
    parameter int unsigned NUM_ENTITIES = 4,
    parameter int unsigned Y_WIDTH      = 10
`ifdef SPRITE_LINE_LIMIT_EN
  , parameter int unsigned MAX_PER_LINE = 2
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic [Y_WIDTH-1:0]        next_y,
    input  logic [NUM_ENTITIES-1:0]   ent_valid,
    input  logic [NUM_ENTITIES*Y_WIDTH-1:0] ent_y,
    input  logic [NUM_ENTITIES*4-1:0] ent_sprite_id,
    input  logic [NUM_ENTITIES*2-1:0] ent_orientation,
    output logic [3:0]                rom_sprite_id,
    output logic [1:0]                rom_orientation,
    output logic [2:0]                rom_line_index,
    input  logic [7:0]                rom_data,
    output logic [NUM_ENTITIES*8-1:0] line_pixels,
    output logic [NUM_ENTITIES-1:0]   line_hit,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    output logic                      line_dropped
);
    import sprite_pkg::*;

    localparam int unsigned SLOT_W = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1;
    localparam int unsigned PIX_W  = NUM_ENTITIES * 8;

    state_t                  r_state, w_state_nxt;
    logic [SLOT_W-1:0]       r_slot, w_sel_slot;
    logic                    r_drain_cnt;
    logic [Y_WIDTH-1:0]      r_y, w_cmp_y;
    logic                    w_issue, w_commit;

    logic [Y_WIDTH-1:0]      w_sel_y;
    logic [3:0]              w_sel_id;
    logic [1:0]              w_sel_ori;
    logic                    w_sel_valid;
    logic                    w_hit, w_hit_eff;
    logic [2:0]              w_line_index;

    rom_req_t                r_rom_req;
    logic                    r_vld1, r_vld2, r_hit1, r_hit2;
    logic [SLOT_W-1:0]       r_idx1, r_idx2;
    logic [PIX_W-1:0]        r_shadow, r_line_pixels;
    logic [NUM_ENTITIES-1:0] r_shadow_hit, r_line_hit;
    logic                    r_busy, r_done, r_overrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Request for slot 0 is issued on the accepting edge; SCAN issues the rest back to back.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_commit    = 1'b0;
        w_sel_slot  = '0;
        w_cmp_y     = next_y;
        unique case (r_state)
            ST_IDLE: begin
                if (line_start) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_sel_slot = r_slot + SLOT_W'(1);
                w_cmp_y    = r_y;
                w_issue    = 1'b1;
                if (w_sel_slot == SLOT_W'(NUM_ENTITIES - 1)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drain_cnt) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_sel_y     = ent_y[w_sel_slot*Y_WIDTH +: Y_WIDTH];
    assign w_sel_id    = ent_sprite_id[w_sel_slot*4 +: 4];
    assign w_sel_ori   = ent_orientation[w_sel_slot*2 +: 2];
    assign w_sel_valid = ent_valid[w_sel_slot];

    sprite_row_hit #(
        .Y_WIDTH (Y_WIDTH)
    ) u_row_hit (
        .i_y            (w_cmp_y),
        .i_ent_y        (w_sel_y),
        .i_valid        (w_sel_valid),
        .o_hit_c        (w_hit),
        .o_line_index_c (w_line_index)
    );

`ifdef SPRITE_LINE_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(NUM_ENTITIES + 1);

    logic [CNT_W-1:0] r_hit_cnt, w_cnt_cur;
    logic             r_drop_seen, w_drop_cur, w_under_cap, r_line_dropped;

    // Counts start fresh on the accepting edge, so IDLE reads them as zero.
    always_comb begin
        w_cnt_cur   = (r_state == ST_IDLE) ? '0   : r_hit_cnt;
        w_drop_cur  = (r_state == ST_IDLE) ? 1'b0 : r_drop_seen;
        w_under_cap = 32'(w_cnt_cur) < MAX_PER_LINE;
        w_hit_eff   = w_hit && w_under_cap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_cnt      <= '0;
            r_drop_seen    <= 1'b0;
            r_line_dropped <= 1'b0;
        end else begin
            r_line_dropped <= 1'b0;
            if (w_issue) begin
                r_hit_cnt   <= w_cnt_cur + CNT_W'(w_hit_eff);
                r_drop_seen <= w_drop_cur | (w_hit & ~w_under_cap);
            end
            if (w_commit) r_line_dropped <= r_drop_seen;
        end
    end

    assign line_dropped = r_line_dropped;
`else
    assign w_hit_eff    = w_hit;
    assign line_dropped = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_drain_cnt <= 1'b0;
        else        r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
    end

    // Request, two-stage hit/slot pipeline to the ROM return, shadow capture and commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot        <= '0;
            r_y           <= '0;
            r_rom_req     <= '{sprite_id: SPRITE_ID_EMPTY, orientation: ORIENT_UP, line_index: '0};
            r_vld1        <= 1'b0;
            r_vld2        <= 1'b0;
            r_hit1        <= 1'b0;
            r_hit2        <= 1'b0;
            r_idx1        <= '0;
            r_idx2        <= '0;
            r_shadow      <= {NUM_ENTITIES{BLANK_ROW}};
            r_shadow_hit  <= '0;
            r_line_pixels <= {NUM_ENTITIES{BLANK_ROW}};
            r_line_hit    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (line_start && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            if ((r_state == ST_IDLE) && line_start) begin
                r_y    <= next_y;
                r_busy <= 1'b1;
            end
            if (w_issue) begin
                r_rom_req.sprite_id   <= w_hit_eff ? w_sel_id : SPRITE_ID_EMPTY;
                r_rom_req.orientation <= w_sel_ori;
                r_rom_req.line_index  <= w_line_index;
                r_slot                <= w_sel_slot;
            end
            r_vld1 <= w_issue;
            r_hit1 <= w_hit_eff;
            r_idx1 <= w_sel_slot;
            r_vld2 <= r_vld1;
            r_hit2 <= r_hit1;
            r_idx2 <= r_idx1;
            if (r_vld2) begin
                r_shadow[r_idx2*8 +: 8] <= r_hit2 ? rom_data : BLANK_ROW;
                r_shadow_hit[r_idx2]    <= r_hit2;
            end
            if (w_commit) begin
                r_line_pixels <= r_shadow;
                r_line_hit    <= r_shadow_hit;
                r_done        <= 1'b1;
                r_busy        <= 1'b0;
            end
        end
    end

    assign rom_sprite_id   = r_rom_req.sprite_id;
    assign rom_orientation = r_rom_req.orientation;
    assign rom_line_index  = r_rom_req.line_index;
    assign line_pixels     = r_line_pixels;
    assign line_hit        = r_line_hit;
    assign busy            = r_busy;
    assign done            = r_done;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized self-checking bench for sprite_line_scheduler against a per-line reference model.
module tb_sprite_line_scheduler;
    import sprite_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned YW = 10;
`ifdef SPRITE_LINE_LIMIT_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = N;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              line_start;
    logic [YW-1:0]     next_y;
    logic [N-1:0]      ent_valid;
    logic [N*YW-1:0]   ent_y;
    logic [N*4-1:0]    ent_sprite_id;
    logic [N*2-1:0]    ent_orientation;
    logic [3:0]        rom_sprite_id;
    logic [1:0]        rom_orientation;
    logic [2:0]        rom_line_index;
    logic [7:0]        rom_data;
    logic [N*8-1:0]    line_pixels;
    logic [N-1:0]      line_hit;
    logic              busy, done, overrun, line_dropped;

    sprite_line_scheduler #(
        .NUM_ENTITIES (N),
        .Y_WIDTH      (YW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .line_start      (line_start),
        .next_y          (next_y),
        .ent_valid       (ent_valid),
        .ent_y           (ent_y),
        .ent_sprite_id   (ent_sprite_id),
        .ent_orientation (ent_orientation),
        .rom_sprite_id   (rom_sprite_id),
        .rom_orientation (rom_orientation),
        .rom_line_index  (rom_line_index),
        .rom_data        (rom_data),
        .line_pixels     (line_pixels),
        .line_hit        (line_hit),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun),
        .line_dropped    (line_dropped)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: request sampled on an edge, row presented after it.
    logic [7:0] rom_tbl [512];
    always @(posedge clk) rom_data <= rom_tbl[{rom_sprite_id, rom_orientation, rom_line_index}];

    int n_tests = 0;
    int n_fail  = 0;

    logic          m_valid [N];
    logic [YW-1:0] m_y     [N];
    logic [3:0]    m_id    [N];
    logic [1:0]    m_ori   [N];
    logic [N*8-1:0] m_prev_pix;
    bit            m_overrun;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load_table();
        for (int k = 0; k < N; k++) begin
            ent_valid[k]               = m_valid[k];
            ent_y[k*YW +: YW]          = m_y[k];
            ent_sprite_id[k*4 +: 4]    = m_id[k];
            ent_orientation[k*2 +: 2]  = m_ori[k];
        end
    endtask

    task automatic clear_table();
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_y[k]     = '0;
            m_id[k]    = '0;
            m_ori[k]   = ORIENT_UP;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pix"},     line_pixels, {N{8'hFF}});
        check({tag, "_hit"},     line_hit, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_done"},    done, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_dropped"}, line_dropped, 0);
        check({tag, "_rom_id"},  rom_sprite_id, 4'hF);
        check({tag, "_rom_ori"}, rom_orientation, 0);
        check({tag, "_rom_idx"}, rom_line_index, 0);
    endtask

    // One full line: expected requests and committed line derived from the entity table.
    task automatic run_line(input logic [YW-1:0] y, input bit inject);
        logic [N*8-1:0] exp_pix;
        logic [N-1:0]   exp_hit;
        logic [3:0]     exp_id  [N];
        logic [2:0]     exp_idx [N];
        bit             exp_drop;
        int             loaded;
        int             cyc;
        loaded   = 0;
        exp_drop = 0;
        for (int k = 0; k < N; k++) begin
            logic [YW-1:0] d;
            d          = y - m_y[k];
            exp_idx[k] = d[2:0];
            exp_hit[k] = 1'b0;
            exp_pix[k*8 +: 8] = 8'hFF;
            if (m_valid[k] && d < 8) begin
                if (loaded < int'(CAP)) begin
                    loaded++;
                    exp_hit[k]        = 1'b1;
                    exp_pix[k*8 +: 8] = rom_tbl[{m_id[k], m_ori[k], d[2:0]}];
                end else begin
                    exp_drop = 1;
                end
            end
            exp_id[k] = exp_hit[k] ? m_id[k] : 4'hF;
        end

        @(negedge clk);
        load_table();
        @(negedge clk);
        next_y     = y;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("rom_id", rom_sprite_id, exp_id[k]);
            if (exp_hit[k]) begin
                check("rom_ori", rom_orientation, m_ori[k]);
                check("rom_idx", rom_line_index, exp_idx[k]);
            end
            check("busy_scan", busy, 1);
            check("pix_stable", line_pixels, m_prev_pix);
            check("done_early", done, 0);
            if (inject && k == 1) line_start = 1'b1;
            if (inject && k == 2) line_start = 1'b0;
            @(negedge clk);
        end
        if (inject) m_overrun = 1;

        cyc = 0;
        while (done !== 1'b1 && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        check("done_latency", cyc, 2);
        check("line_pixels", line_pixels, exp_pix);
        check("line_hit", line_hit, exp_hit);
        check("busy_done", busy, 0);
        check("line_dropped", line_dropped, exp_drop);
        check("overrun", overrun, m_overrun);
        m_prev_pix = exp_pix;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("pix_hold", line_pixels, exp_pix);
    endtask

    task automatic reset_mid_scan();
        bit saw_done;
        @(negedge clk);
        load_table();
        next_y     = 10'd50;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        reset      = 1'b1;
        m_prev_pix = {N{8'hFF}};
        m_overrun  = 0;
        saw_done   = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("no_done_after_rst", saw_done, 0);
    endtask

    task automatic randomize_table(input logic [YW-1:0] y, input bit all_hit);
        for (int k = 0; k < N; k++) begin
            m_valid[k] = all_hit ? 1'b1 : ($urandom_range(0, 3) != 0);
            m_y[k]     = all_hit ? YW'(y - YW'(k)) : YW'(y - YW'($urandom_range(0, 12)));
            m_id[k]    = 4'($urandom);
            m_ori[k]   = 2'($urandom);
        end
    endtask

    initial begin
        logic [YW-1:0] ry;
        for (int a = 0; a < 512; a++) rom_tbl[a] = 8'($urandom);
        reset      = 1'b0;
        line_start = 1'b0;
        next_y     = '0;
        clear_table();
        load_table();
        m_prev_pix = {N{8'hFF}};
        m_overrun  = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;

        // Single sprite at 100, row 3.
        clear_table();
        m_valid[0] = 1'b1;
        m_y[0]     = 10'd100;
        m_id[0]    = 4'd0;
        m_ori[0]   = ORIENT_UP;
        run_line(10'd103, 0);
        check("first_hit_mask", line_hit, 4'b0001);

        // Row-range boundaries and wrap-around.
        run_line(10'd99, 0);
        run_line(10'd100, 0);
        run_line(10'd107, 0);
        run_line(10'd108, 0);
        m_y[0] = 10'd1020;
        m_id[0] = 4'd5;
        m_ori[0] = ORIENT_LEFT;
        run_line(10'd2, 0);

        // Every slot hits.
        randomize_table(10'd200, 1);
        run_line(10'd203, 0);

        // line_start during SCAN is ignored and latches overrun.
        randomize_table(10'd400, 0);
        run_line(10'd400, 1);
        randomize_table(10'd10, 0);
        run_line(10'd10, 0);

        reset_mid_scan();
        randomize_table(10'd600, 1);
        run_line(10'd601, 0);

        for (int i = 0; i < 40; i++) begin
            ry = YW'($urandom);
            randomize_table(ry, ($urandom_range(0, 4) == 0));
            run_line(ry, ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
